store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
//  Word-wide posted-write FIFO between the mips core data port and the single-port dmem.
//  - Stores retire into the buffer in one cycle; the core never waits on dmem writes.
//  - Entries drain to dmem on cycles when the core is not using the port for a load.
//  - Loads get priority on the dmem port and see pending stores through address matching.
// PARAMETERS
//  DEPTH  4   entries; power of two, >=2
//  AW     32  address width; word compare uses addr[AW-1:2]
//  DW     32  data width
// PORTS
//  clk        in   1   single clock; all state updates on rising edge
//  reset      in   1   synchronous, active-high
//  cpu_we     in   1   core store request
//  cpu_re     in   1   core load request
//  cpu_addr   in   AW  core byte address (addr[1:0] ignored)
//  cpu_wdata  in   DW  store data
//  cpu_rdata  out  DW  load data, combinational in the same cycle as cpu_re
//  cpu_stall  out  1   core must hold its request and retry next cycle
//  mem_we     out  1   dmem write strobe
//  mem_addr   out  AW  dmem address
//  mem_wdata  out  DW  dmem write data
//  mem_rdata  in   DW  dmem read data, combinational from mem_addr
//  sb_empty   out  1   no pending stores; software/IO fence polls this
// BEHAVIOUR
//  State and reset
//   - Circular FIFO: head/tail pointers of log2(DEPTH) bits, count of log2(DEPTH)+1 bits.
//   - Reset (synchronous) clears head, tail and count; entry contents are don't-care.
//   - Outputs while in reset and the cycle after: mem_we=0, cpu_stall=0, sb_empty=1.
//   - Reset mid-drain discards all pending entries; no write is issued on the reset cycle.
//  Port arbitration (combinational)
//   - drain = (count!=0) && !cpu_re
//   - mem_we = drain
//   - mem_addr = cpu_re ? cpu_addr : head_addr
//   - mem_wdata = head_data
//  Push
//   - accept = cpu_we && !cpu_stall; the entry is written at tail and tail advances.
//   - An accepted store is never visible at dmem in the same cycle; earliest drain is the next cycle.
//  Pop
//   - On drain, head advances at the clock edge (dmem captures the write on the same edge).
//  Count and pointers
//   - Push+pop in the same cycle leaves count unchanged.
//   - Both pointers wrap modulo DEPTH.
//  Full
//   - cpu_stall on a store = full && !drain; the store is accepted whenever a pop frees a slot that cycle.
//  Load hit
//   - match = any valid entry whose addr[AW-1:2] equals cpu_addr[AW-1:2]; the youngest match wins.
//  Illegal input
//   - cpu_we && cpu_re together is illegal; the bench flags it with an assertion.
//   - RTL then serves the load, enqueues the store, and that store is not forwarded.
//  sb_empty = (count==0).
// CONFIGURATION
//  STORE_BUFFER_FWD_EN defined
//   - Load hit: cpu_rdata = youngest matching entry data; cpu_stall=0.
//   - Load miss: cpu_rdata = mem_rdata.
//  STORE_BUFFER_FWD_EN undefined
//   - Load hit: cpu_stall=1, mem_addr = head_addr and drain proceeds (the load yields the port).
//   - The stall holds until no match remains; the load then reads mem_rdata.
// TESTING
//  T1 reset
//   - Assert reset 2 cycles with cpu_we=1 -> count=0, sb_empty=1, mem_we=0 throughout.
//  T2 single store
//   - Store 0xDEADBEEF @0x10, then idle -> mem_we=1, mem_addr=0x10, mem_wdata=0xDEADBEEF exactly 1 cycle later.
//   - sb_empty=1 the cycle after that.
//  T3 fill with loads
//   - 4 stores, with a load asserted each following cycle so no drain occurs -> 5th store sees cpu_stall=1.
//   - Drop cpu_re -> the 5th store is accepted in the same cycle as the first drain.
//  T4 youngest-hit forward (FWD_EN)
//   - Stores 0x1111 @0x20 then 0x2222 @0x20; load @0x23 with dmem holding 0 -> cpu_rdata=0x2222, cpu_stall=0.
//  T5 no-forward stall (FWD_EN off)
//   - Same stimulus as T4 -> cpu_stall=1 for 2 cycles while both entries drain.
//   - Then cpu_rdata=0x2222 from dmem.
//  T6 reset mid-drain
//   - 3 stores pending; reset 1 cycle -> no further mem_we; dmem is unchanged for the undrained entries.

Source files
------------

// File: rtl/store_buffer.sv
// Posted-write store buffer between the core data port and single-port dmem.
// Optional store-to-load forwarding is enabled by defining STORE_BUFFER_FWD_EN.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_we,
  input  logic          cpu_re,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          sb_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic          full;
  logic          hit;
  logic          load_stall;
  logic          load_go;
  logic          drain;
  logic          store_stall;
  logic          accept;
`ifdef STORE_BUFFER_FWD_EN
  logic [DW-1:0] hit_data;
`endif

  // Walk entries oldest to youngest so the youngest word match wins.
  always_comb begin
    hit = 1'b0;
`ifdef STORE_BUFFER_FWD_EN
    hit_data = '0;
`endif
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count) &&
          (addr_q[head + PW'(k)][AW-1:2] == cpu_addr[AW-1:2])) begin
        hit = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
        hit_data = data_q[head + PW'(k)];
`endif
      end
    end
  end

  // Port arbitration: a load owns dmem unless it must yield to let matching stores drain.
  always_comb begin
    full = (count == CW'(DEPTH));
`ifdef STORE_BUFFER_FWD_EN
    load_stall = 1'b0;
`else
    load_stall = cpu_re && hit;
`endif
    load_go     = cpu_re && !load_stall;
    drain       = !reset && (count != '0) && !load_go;
    store_stall = cpu_we && full && !drain;
    cpu_stall   = !reset && (load_stall || store_stall);
    accept      = !reset && cpu_we && !cpu_stall;
    sb_empty    = reset || (count == '0);
    mem_we      = drain;
    mem_addr    = load_go ? cpu_addr : addr_q[head];
    mem_wdata   = data_q[head];
`ifdef STORE_BUFFER_FWD_EN
    cpu_rdata   = hit ? hit_data : mem_rdata;
`else
    cpu_rdata   = mem_rdata;
`endif
  end

  // Pointers and occupancy; reset discards any pending entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (accept) tail <= tail + PW'(1);
      if (drain)  head <= head + PW'(1);
      case ({accept, drain})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset; validity is implied by head/count.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q[tail] <= cpu_addr;
      data_q[tail] <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic
// checked against a queue-based model of the buffer and a reference dmem image.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_we;
  logic          cpu_re;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          sb_empty;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .sb_empty(sb_empty)
  );

  always #5 clk = ~clk;

  // Environment dmem: combinational read, written on the edge by the DUT.
  logic [31:0] dmem [256] = '{default: 32'h0};
  assign mem_rdata = dmem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) dmem[mem_addr[9:2]] <= mem_wdata;

  // Reference model state.
  typedef struct { logic [31:0] addr; logic [31:0] data; } ent_t;
  ent_t        q[$];
  logic [31:0] ref_mem [256];
  int          errors = 0;
  int          checks = 0;
  logic        illegal_ok = 1'b0;
  logic        cur_rst;
  logic        exp_stall, exp_drain, exp_empty, exp_push, exp_load_go;
  logic [31:0] exp_rdata, exp_maddr, exp_mwdata;

  always @(negedge clk)
    if (reset === 1'b0 && illegal_ok === 1'b0)
      assert (!(cpu_we && cpu_re)) else $error("illegal cpu_we and cpu_re together");

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Apply one cycle of inputs, predict outputs, return at the falling edge.
  task automatic drive(input logic rst, input logic we, input logic re,
                       input logic [31:0] a, input logic [31:0] d);
    logic hit;
    logic load_stall;
`ifdef STORE_BUFFER_FWD_EN
    logic [31:0] hit_data;
`endif
    reset = rst; cpu_we = we; cpu_re = re; cpu_addr = a; cpu_wdata = d;
    cur_rst = rst;
    hit = 1'b0;
`ifdef STORE_BUFFER_FWD_EN
    hit_data = 32'h0;
    foreach (q[i]) if (q[i].addr[31:2] == a[31:2]) begin hit = 1'b1; hit_data = q[i].data; end
    load_stall = 1'b0;
    exp_rdata  = hit ? hit_data : ref_mem[a[9:2]];
`else
    foreach (q[i]) if (q[i].addr[31:2] == a[31:2]) hit = 1'b1;
    load_stall = re && hit;
    exp_rdata  = ref_mem[a[9:2]];
`endif
    exp_load_go = re && !load_stall;
    exp_drain   = !rst && (q.size() != 0) && !exp_load_go;
    exp_stall   = !rst && (load_stall || (we && q.size() == int'(DEPTH) && !exp_drain));
    exp_push    = !rst && we && !exp_stall;
    exp_empty   = rst || (q.size() == 0);
    exp_maddr   = exp_load_go ? a : ((q.size() != 0) ? q[0].addr : 32'h0);
    exp_mwdata  = (q.size() != 0) ? q[0].data : 32'h0;
    @(negedge clk);
  endtask

  // Clock edge: retire the predicted drain into the reference image, then push.
  task automatic tick();
    @(posedge clk);
    if (cur_rst) q.delete();
    else begin
      if (exp_drain) begin
        ref_mem[q[0].addr[9:2]] = q[0].data;
        void'(q.pop_front());
      end
      if (exp_push) q.push_back('{cpu_addr, cpu_wdata});
    end
    #1;
  endtask

  task automatic settle();
    for (int c = 0; c < 2 * int'(DEPTH) && q.size() != 0; c++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
    end
    checks++;
    if (q.size() != 0 || sb_empty !== 1'b1) begin errors++; $display("FAIL settle: sb_empty=%0b pending=%0d expected empty", sb_empty, q.size()); end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h100 + 32'(c * 4), 32'hCAFE0000 + 32'(c));
      checks += 3;
      if (mem_we !== 1'b0)    begin errors++; $display("FAIL reset_mem_we: got %0b expected 0", mem_we); end
      if (sb_empty !== 1'b1)  begin errors++; $display("FAIL reset_sb_empty: got %0b expected 1", sb_empty); end
      if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b expected 0", cpu_stall); end
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks += 3;
    if (mem_we !== 1'b0)    begin errors++; $display("FAIL post_reset_mem_we: got %0b expected 0", mem_we); end
    if (sb_empty !== 1'b1)  begin errors++; $display("FAIL post_reset_sb_empty: got %0b expected 1", sb_empty); end
    if (cpu_stall !== 1'b0) begin errors++; $display("FAIL post_reset_stall: got %0b expected 0", cpu_stall); end
    tick();
  endtask

  task automatic test_single_store();
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
    checks += 2;
    if (mem_we !== 1'b0)    begin errors++; $display("FAIL single_same_cycle_we: got %0b expected 0", mem_we); end
    if (cpu_stall !== 1'b0) begin errors++; $display("FAIL single_stall: got %0b expected 0", cpu_stall); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks += 4;
    if (mem_we !== 1'b1)           begin errors++; $display("FAIL single_mem_we: got %0b expected 1", mem_we); end
    if (mem_addr !== 32'h10)       begin errors++; $display("FAIL single_mem_addr: got %h expected 00000010", mem_addr); end
    if (mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_mem_wdata: got %h expected deadbeef", mem_wdata); end
    if (sb_empty !== 1'b0)         begin errors++; $display("FAIL single_pending: got %0b expected 0", sb_empty); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks += 2;
    if (sb_empty !== 1'b1) begin errors++; $display("FAIL single_empty_after: got %0b expected 1", sb_empty); end
    if (mem_we !== 1'b0)   begin errors++; $display("FAIL single_no_second_write: got %0b expected 0", mem_we); end
    tick();
  endtask

  task automatic test_fill();
    illegal_ok = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 32'h40, 32'hA0);
    tick();
    for (int k = 1; k < 4; k++) begin
      drive(1'b0, 1'b1, 1'b1, 32'h40 + 32'(k * 4), 32'hA0 + 32'(k));
      checks += 3;
      if (cpu_stall !== 1'b0)    begin errors++; $display("FAIL fill_stall_%0d: got %0b expected 0", k, cpu_stall); end
      if (mem_we !== 1'b0)       begin errors++; $display("FAIL fill_no_drain_%0d: got %0b expected 0", k, mem_we); end
      if (cpu_rdata !== exp_rdata) begin errors++; $display("FAIL fill_load_data_%0d: got %h expected %h", k, cpu_rdata, exp_rdata); end
      tick();
    end
    drive(1'b0, 1'b1, 1'b1, 32'h50, 32'hA4);
    checks += 2;
    if (cpu_stall !== 1'b1) begin errors++; $display("FAIL fill_full_stall: got %0b expected 1", cpu_stall); end
    if (mem_we !== 1'b0)    begin errors++; $display("FAIL fill_full_no_drain: got %0b expected 0", mem_we); end
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h50, 32'hA4);
    checks += 4;
    if (cpu_stall !== 1'b0)   begin errors++; $display("FAIL fill_accept_on_pop: got %0b expected 0", cpu_stall); end
    if (mem_we !== 1'b1)      begin errors++; $display("FAIL fill_first_drain: got %0b expected 1", mem_we); end
    if (mem_addr !== 32'h40)  begin errors++; $display("FAIL fill_drain_addr: got %h expected 00000040", mem_addr); end
    if (mem_wdata !== 32'hA0) begin errors++; $display("FAIL fill_drain_data: got %h expected 000000a0", mem_wdata); end
    tick();
    illegal_ok = 1'b0;
    checks++;
    if (sb_empty !== 1'b0 || q.size() != int'(DEPTH)) begin errors++; $display("FAIL fill_still_full: sb_empty=%0b model=%0d expected 0 and %0d", sb_empty, q.size(), DEPTH); end
    settle();
  endtask

  task automatic test_forward();
    illegal_ok = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 32'h80, 32'h8080);
    tick();
    drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h1111);
    tick();
    illegal_ok = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'h20, 32'h2222);
    tick();
`ifdef STORE_BUFFER_FWD_EN
    drive(1'b0, 1'b0, 1'b1, 32'h23, 32'h0);
    checks += 3;
    if (cpu_stall !== 1'b0)     begin errors++; $display("FAIL fwd_stall: got %0b expected 0", cpu_stall); end
    if (cpu_rdata !== 32'h2222) begin errors++; $display("FAIL fwd_youngest: got %h expected 00002222", cpu_rdata); end
    if (mem_we !== 1'b0)        begin errors++; $display("FAIL fwd_load_owns_port: got %0b expected 0", mem_we); end
    tick();
`else
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 1'b0, 1'b1, 32'h23, 32'h0);
      checks += 3;
      if (cpu_stall !== 1'b1)  begin errors++; $display("FAIL nofwd_stall_%0d: got %0b expected 1", c, cpu_stall); end
      if (mem_we !== 1'b1)     begin errors++; $display("FAIL nofwd_drain_%0d: got %0b expected 1", c, mem_we); end
      if (mem_addr !== 32'h20) begin errors++; $display("FAIL nofwd_head_addr_%0d: got %h expected 00000020", c, mem_addr); end
      tick();
    end
    drive(1'b0, 1'b0, 1'b1, 32'h23, 32'h0);
    checks += 2;
    if (cpu_stall !== 1'b0)     begin errors++; $display("FAIL nofwd_release: got %0b expected 0", cpu_stall); end
    if (cpu_rdata !== 32'h2222) begin errors++; $display("FAIL nofwd_dmem_data: got %h expected 00002222", cpu_rdata); end
    tick();
`endif
    settle();
  endtask

  task automatic test_reset_mid_drain();
    illegal_ok = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 32'h60, 32'h6A);
    tick();
    drive(1'b0, 1'b1, 1'b1, 32'h64, 32'h6B);
    tick();
    drive(1'b0, 1'b1, 1'b1, 32'h68, 32'h6C);
    tick();
    illegal_ok = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    checks += 2;
    if (mem_we !== 1'b0)   begin errors++; $display("FAIL rstmid_no_write: got %0b expected 0", mem_we); end
    if (sb_empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty: got %0b expected 1", sb_empty); end
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      checks += 2;
      if (mem_we !== 1'b0)   begin errors++; $display("FAIL rstmid_after_we_%0d: got %0b expected 0", c, mem_we); end
      if (sb_empty !== 1'b1) begin errors++; $display("FAIL rstmid_after_empty_%0d: got %0b expected 1", c, sb_empty); end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dmem[24 + k] !== ref_mem[24 + k]) begin errors++; $display("FAIL rstmid_dmem_%0d: got %h expected %h", k, dmem[24 + k], ref_mem[24 + k]); end
    end
  endtask

  task automatic test_random();
    int unsigned op;
    logic [31:0] a;
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 9);
      a  = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      drive(1'b0, op < 4, op >= 4 && op < 7, a, $urandom);
      checks += 3;
      if (cpu_stall !== exp_stall) begin errors++; $display("FAIL rand_stall@%0d: got %0b expected %0b", n, cpu_stall, exp_stall); end
      if (mem_we !== exp_drain)    begin errors++; $display("FAIL rand_mem_we@%0d: got %0b expected %0b", n, mem_we, exp_drain); end
      if (sb_empty !== exp_empty)  begin errors++; $display("FAIL rand_empty@%0d: got %0b expected %0b", n, sb_empty, exp_empty); end
      if (exp_load_go || exp_drain) begin
        checks++;
        if (mem_addr !== exp_maddr) begin errors++; $display("FAIL rand_mem_addr@%0d: got %h expected %h", n, mem_addr, exp_maddr); end
      end
      if (exp_drain) begin
        checks++;
        if (mem_wdata !== exp_mwdata) begin errors++; $display("FAIL rand_mem_wdata@%0d: got %h expected %h", n, mem_wdata, exp_mwdata); end
      end
      if (exp_load_go) begin
        checks++;
        if (cpu_rdata !== exp_rdata) begin errors++; $display("FAIL rand_rdata@%0d: got %h expected %h", n, cpu_rdata, exp_rdata); end
      end
      tick();
    end
    settle();
    for (int w = 0; w < 8; w++) begin
      checks++;
      if (dmem[w] !== ref_mem[w]) begin errors++; $display("FAIL rand_final_dmem_%0d: got %h expected %h", w, dmem[w], ref_mem[w]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    test_reset();
    test_single_store();
    test_fill();
    test_forward();
    test_reset_mid_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
